// File: rtl/mc_ctrl_fsm.sv
// Opcode-aware multi-cycle CPU controller with a memory req/ready handshake,
// a wait-state timeout, illegal-opcode trapping and a retired-instruction counter.
module mc_ctrl_fsm #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             mdr_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             alu_out_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             instr_done,
  output logic             err,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state
);

  localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_ERR = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [WAIT_W-1:0]   r_wait;
  logic [CNT_W-1:0]    r_retired;
  logic                w_timeout;
  logic                w_waiting;

  // A memory wait is counted only while an access is pending without ready.
  assign w_waiting = ((r_state == S_IF) || (r_state == S_MEM)) && !mem_ready;
  // Expires when cycle TIMEOUT of the access still lacks ready.
  assign w_timeout = (TIMEOUT != 0) && w_waiting &&
                     (r_wait == WAIT_W'(TIMEOUT - 1));

  assign state   = r_state;
  assign retired = r_retired;

  // State, wait counter and retired-instruction counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IF;
      r_wait    <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_wait <= '0;
      end else if (w_waiting && (r_wait != '1)) begin
        r_wait <= r_wait + WAIT_W'(1);
      end
      if (instr_done) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  // Next-state and datapath control decode; everything is held at 0 in reset.
  always_comb begin
    w_next        = r_state;
    mem_req       = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    mdr_write     = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    alu_out_write = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    instr_done    = 1'b0;
    err           = 1'b0;

    if (!rst) begin
      case (r_state)
        S_IF: begin
          mem_req   = 1'b1;
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            w_next   = S_ID;
          end else if (w_timeout) begin
            w_next = S_ERR;
          end
        end

        // ALUOut captures the branch target speculatively.
        S_ID: begin
          alu_src_b     = 2'b11;
          alu_out_write = 1'b1;
          case (opcode)
            OP_J: begin
              pc_write   = 1'b1;
              pc_src     = 2'b10;
              instr_done = 1'b1;
              w_next     = S_IF;
            end
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI: w_next = S_EX;
            default: w_next = S_ERR;
          endcase
        end

        S_EX: begin
          alu_src_a = 1'b1;
          case (opcode)
            OP_R: begin
              alu_op        = 2'b10;
              alu_out_write = 1'b1;
              w_next        = S_WB;
            end
            OP_ADDI: begin
              alu_src_b     = 2'b10;
              alu_out_write = 1'b1;
              w_next        = S_WB;
            end
            OP_LW, OP_SW: begin
              alu_src_b     = 2'b10;
              alu_out_write = 1'b1;
              w_next        = S_MEM;
            end
            OP_BEQ: begin
              alu_op     = 2'b01;
              pc_src     = 2'b01;
              pc_write   = zero;
              instr_done = 1'b1;
              w_next     = S_IF;
            end
            default: w_next = S_ERR;
          endcase
        end

        S_MEM: begin
          mem_req   = 1'b1;
          iord      = 1'b1;
          mem_read  = (opcode == OP_LW);
          mem_write = (opcode == OP_SW);
          if (mem_ready) begin
            if (opcode == OP_LW) begin
              mdr_write = 1'b1;
              w_next    = S_WB;
            end else if (opcode == OP_SW) begin
              instr_done = 1'b1;
              w_next     = S_IF;
            end else begin
              w_next = S_ERR;
            end
          end else if (w_timeout) begin
            w_next = S_ERR;
          end
        end

        S_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          reg_dst    = (opcode == OP_R);
          mem_to_reg = (opcode == OP_LW);
          w_next     = S_IF;
        end

        S_ERR: err = 1'b1;

        default: w_next = S_ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm (TIMEOUT = 4, CNT_W = 4): a vector table
// walks every instruction class, then hand sequences cover reset, timeout and wrap.
module tb_mc_ctrl_fsm;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ILL  = 6'b111111;

  // Bit order: mem_req mem_read mem_write iord ir_write mdr_write pc_write
  // pc_src[2] alu_src_a alu_src_b[2] alu_op[2] alu_out_write reg_write
  // reg_dst mem_to_reg instr_done err
  localparam logic [19:0] C_ZERO   = 20'd0;
  localparam logic [19:0] C_IF_W   = {1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b01,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [19:0] C_IF_R   = {1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,2'b00,1'b0,2'b01,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [19:0] C_ID     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b11,2'b00,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [19:0] C_ID_J   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,2'b11,2'b00,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0};
  localparam logic [19:0] C_EX_R   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b00,2'b10,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [19:0] C_EX_I   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b10,2'b00,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [19:0] C_EX_BZ  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,1'b1,2'b00,2'b01,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0};
  localparam logic [19:0] C_EX_BN  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,1'b1,2'b00,2'b01,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0};
  localparam logic [19:0] C_MLW_W  = {1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [19:0] C_MLW_R  = {1'b1,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [19:0] C_MSW_R  = {1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0};
  localparam logic [19:0] C_WB_R   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0};
  localparam logic [19:0] C_WB_I   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0};
  localparam logic [19:0] C_WB_LW  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0};
  localparam logic [19:0] C_ERR    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1};

  typedef struct {
    logic [5:0]  op;
    logic        zero;
    logic        ready;
    logic [2:0]  exp_state;
    logic [19:0] exp_ctl;
    logic [3:0]  exp_ret;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_read, mem_write, iord, ir_write, mdr_write, pc_write;
  logic [1:0]  pc_src;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic        alu_out_write, reg_write, reg_dst, mem_to_reg, instr_done, err;
  logic [3:0]  retired;
  logic [2:0]  state;
  logic [19:0] w_ctl;

  int n_cmp;
  int n_bad;
  vec_t vecs[$];

  mc_ctrl_fsm #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .ir_write(ir_write), .mdr_write(mdr_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .alu_out_write(alu_out_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .instr_done(instr_done), .err(err),
    .retired(retired), .state(state)
  );

  assign w_ctl = {mem_req, mem_read, mem_write, iord, ir_write, mdr_write, pc_write,
                  pc_src, alu_src_a, alu_src_b, alu_op, alu_out_write, reg_write,
                  reg_dst, mem_to_reg, instr_done, err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input logic [5:0] op, input logic z, input logic r,
                         input logic [2:0] st, input logic [19:0] ctl, input logic [3:0] ret);
    vec_t v;
    v.op = op; v.zero = z; v.ready = r; v.exp_state = st; v.exp_ctl = ctl; v.exp_ret = ret;
    vecs.push_back(v);
  endtask

  task automatic check_now(input string tag, input logic [2:0] st,
                           input logic [19:0] ctl, input logic [3:0] ret);
    check({tag, "_state"}, 32'(state), 32'(st));
    check({tag, "_ctl"}, 32'(w_ctl), 32'(ctl));
    check({tag, "_retired"}, 32'(retired), 32'(ret));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;

    // add, no waits
    add_vec(OP_R, 1'b0, 1'b1, 3'd0, C_IF_R, 4'd0);
    add_vec(OP_R, 1'b0, 1'b1, 3'd1, C_ID,   4'd0);
    add_vec(OP_R, 1'b0, 1'b1, 3'd2, C_EX_R, 4'd0);
    add_vec(OP_R, 1'b0, 1'b1, 3'd4, C_WB_R, 4'd0);
    // addi
    add_vec(OP_ADDI, 1'b0, 1'b1, 3'd0, C_IF_R, 4'd1);
    add_vec(OP_ADDI, 1'b0, 1'b1, 3'd1, C_ID,   4'd1);
    add_vec(OP_ADDI, 1'b0, 1'b1, 3'd2, C_EX_I, 4'd1);
    add_vec(OP_ADDI, 1'b0, 1'b1, 3'd4, C_WB_I, 4'd1);
    // lw, 2 waits in IF, 1 in MEM: 8 cycles
    add_vec(OP_LW, 1'b0, 1'b0, 3'd0, C_IF_W,  4'd2);
    add_vec(OP_LW, 1'b0, 1'b0, 3'd0, C_IF_W,  4'd2);
    add_vec(OP_LW, 1'b0, 1'b1, 3'd0, C_IF_R,  4'd2);
    add_vec(OP_LW, 1'b0, 1'b1, 3'd1, C_ID,    4'd2);
    add_vec(OP_LW, 1'b0, 1'b1, 3'd2, C_EX_I,  4'd2);
    add_vec(OP_LW, 1'b0, 1'b0, 3'd3, C_MLW_W, 4'd2);
    add_vec(OP_LW, 1'b0, 1'b1, 3'd3, C_MLW_R, 4'd2);
    add_vec(OP_LW, 1'b0, 1'b1, 3'd4, C_WB_LW, 4'd2);
    // sw
    add_vec(OP_SW, 1'b0, 1'b1, 3'd0, C_IF_R,  4'd3);
    add_vec(OP_SW, 1'b0, 1'b1, 3'd1, C_ID,    4'd3);
    add_vec(OP_SW, 1'b0, 1'b1, 3'd2, C_EX_I,  4'd3);
    add_vec(OP_SW, 1'b0, 1'b1, 3'd3, C_MSW_R, 4'd3);
    // beq taken / not taken; mem_ready in EX must be ignored
    add_vec(OP_BEQ, 1'b1, 1'b1, 3'd0, C_IF_R,  4'd4);
    add_vec(OP_BEQ, 1'b1, 1'b1, 3'd1, C_ID,    4'd4);
    add_vec(OP_BEQ, 1'b1, 1'b0, 3'd2, C_EX_BZ, 4'd4);
    add_vec(OP_BEQ, 1'b0, 1'b1, 3'd0, C_IF_R,  4'd5);
    add_vec(OP_BEQ, 1'b0, 1'b1, 3'd1, C_ID,    4'd5);
    add_vec(OP_BEQ, 1'b0, 1'b1, 3'd2, C_EX_BN, 4'd5);
    // j
    add_vec(OP_J, 1'b0, 1'b1, 3'd0, C_IF_R, 4'd6);
    add_vec(OP_J, 1'b0, 1'b1, 3'd1, C_ID_J, 4'd6);
    // add with ready on the last allowed cycle (cycle 4)
    add_vec(OP_R, 1'b0, 1'b0, 3'd0, C_IF_W, 4'd7);
    add_vec(OP_R, 1'b0, 1'b0, 3'd0, C_IF_W, 4'd7);
    add_vec(OP_R, 1'b0, 1'b0, 3'd0, C_IF_W, 4'd7);
    add_vec(OP_R, 1'b0, 1'b1, 3'd0, C_IF_R, 4'd7);
    add_vec(OP_R, 1'b0, 1'b1, 3'd1, C_ID,   4'd7);
    add_vec(OP_R, 1'b0, 1'b1, 3'd2, C_EX_R, 4'd7);
    add_vec(OP_R, 1'b0, 1'b1, 3'd4, C_WB_R, 4'd7);
    // illegal opcode traps and ERR is sticky
    add_vec(OP_ILL, 1'b0, 1'b1, 3'd0, C_IF_R, 4'd8);
    add_vec(OP_ILL, 1'b0, 1'b1, 3'd1, C_ID,   4'd8);
    add_vec(OP_ILL, 1'b0, 1'b1, 3'd5, C_ERR,  4'd8);
    add_vec(OP_R,   1'b0, 1'b1, 3'd5, C_ERR,  4'd8);

    rst = 1'b1; opcode = OP_R; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_now("reset", 3'd0, C_ZERO, 4'd0);

    foreach (vecs[i]) begin
      if (i > 0) @(negedge clk);
      else rst = 1'b0;
      opcode = vecs[i].op; zero = vecs[i].zero; mem_ready = vecs[i].ready;
      #1;
      check_now($sformatf("vec%0d", i), vecs[i].exp_state, vecs[i].exp_ctl, vecs[i].exp_ret);
    end

    // Reset while in ERR
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b1;
    #1;
    check_now("rst_in_err", 3'd0, C_ZERO, 4'd0);

    // Timeout: ready held low in IF for 4 cycles
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b0; opcode = OP_R;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      check_now($sformatf("tmo_if%0d", c), 3'd0, C_IF_W, 4'd0);
    end
    @(negedge clk);
    #1;
    check_now("tmo_err", 3'd5, C_ERR, 4'd0);

    // Retired counter wrap with 16 jumps
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; opcode = OP_J; mem_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      check_now($sformatf("wrap_if%0d", i), 3'd0, C_IF_R, 4'(i));
      @(negedge clk);
      #1;
      check_now($sformatf("wrap_id%0d", i), 3'd1, C_ID_J, 4'(i));
    end
    @(negedge clk);
    #1;
    check_now("wrap_end", 3'd0, C_IF_R, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
